// File: rtl/i2c_sensor_pkg.sv
// Shared definitions for the environmental sensor I2C subsystem.
// Holds the poll slot table (7-bit slave addresses and the data register
// read in each slot), the slot index type and the scheduler state encoding.
// Also imported by the I2C master and the MLP input stage.
package i2c_sensor_pkg;

  localparam logic [6:0] ADDR_SHT31   = 7'h44;  // temperature
  localparam logic [6:0] ADDR_CCS811  = 7'h5A;  // eCO2
  localparam logic [6:0] ADDR_LPS22HB = 7'h5C;  // pressure
  localparam logic [6:0] ADDR_BH1750  = 7'h23;  // light

  // Every sensor exposes its reading at register 0x00.
  localparam logic [7:0] REG_DATA = 8'h00;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_LAST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } sched_state_t;

  function automatic logic [6:0] slot_addr(input slot_t slot);
    logic [6:0] addr;
    unique case (slot)
      2'd0:    addr = ADDR_SHT31;
      2'd1:    addr = ADDR_CCS811;
      2'd2:    addr = ADDR_LPS22HB;
      default: addr = ADDR_BH1750;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/i2c_poll_timer.sv
// Frame-rate timer for the sensor poll scheduler.
// Counts clk cycles while enable is high and raises tick for one cycle every
// POLL_DIV cycles; the count is held at zero while enable is low, so the
// first tick after enabling lands POLL_DIV cycles later.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   enable  in   polling enable; low clears the count
//   tick    out  frame tick, high in the cycle the count sits at POLL_DIV-1
module i2c_poll_timer #(
  parameter int POLL_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(POLL_DIV);

  logic [CW-1:0] cnt;
  logic          at_wrap;

  assign at_wrap = (cnt == CW'(POLL_DIV - 1));
  assign tick    = enable && at_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || at_wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_sensor_scheduler.sv
// Round-robin poll scheduler for the four environmental sensors on the shared
// I2C bus. Each frame issues one register read per sensor to the I2C master
// byte engine (retrying on NACK up to MAX_RETRY extra times), latches good
// readings into holding registers and pulses sample_valid once the whole
// frame has been walked.
//
// Optional build macro SCHED_TIMEOUT_EN adds a watchdog on mst_done: a
// transaction that sees no done within TIMEOUT_CYC cycles is handled as a
// NACK, and err_flags grows a sticky bit 4 recording that a timeout happened.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   enable                  polling enable
//   mst_cmd_valid/ready     request handshake to the I2C master
//   mst_cmd_addr/reg        7-bit slave address / register of the request
//   mst_done/nack/rdata     completion pulse, NACK qualifier, 16-bit read data
//   temp_o/eco2_o/press_o/light_o   last good reading per sensor
//   sample_valid            one-cycle pulse at the end of a completed frame
//   err_flags               per-slot failure of latest attempt (+ bit 4 with macro)
//   overrun                 sticky: frame tick arrived while a frame was running
//   busy                    scheduler not idle
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a frame tick
// S_ISSUE | request for current slot presented to the master
// S_WAIT  | request accepted, waiting for mst_done (or watchdog)
// S_NEXT  | slot finished, advance or wrap up the frame
// S_DONE  | frame complete, sample_valid high for this cycle
module i2c_sensor_scheduler
  import i2c_sensor_pkg::*;
#(
  parameter int POLL_DIV  = 100000,
  parameter int MAX_RETRY = 2
`ifdef SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 50000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        mst_cmd_valid,
  input  logic        mst_cmd_ready,
  output logic [6:0]  mst_cmd_addr,
  output logic [7:0]  mst_cmd_reg,
  input  logic        mst_done,
  input  logic        mst_nack,
  input  logic [15:0] mst_rdata,
  output logic [15:0] temp_o,
  output logic [15:0] eco2_o,
  output logic [15:0] press_o,
  output logic [15:0] light_o,
  output logic        sample_valid,
`ifdef SCHED_TIMEOUT_EN
  output logic [4:0]  err_flags,
`else
  output logic [3:0]  err_flags,
`endif
  output logic        overrun,
  output logic        busy
);

  sched_state_t state, state_nxt;
  slot_t        slot, slot_nxt;
  logic [2:0]   retry, retry_nxt;
  logic         tick;
  logic         done_eff, nack_eff;
  logic         xact_ok, xact_fail;
  logic [3:0]   err_q;

  i2c_poll_timer #(
    .POLL_DIV (POLL_DIV)
  ) u_poll_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

`ifdef SCHED_TIMEOUT_EN
  localparam int WDW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WDW-1:0] wd_cnt;
  logic           wd_expire;
  logic           timeout_seen;

  // Reloaded whenever we are outside WAIT, so every attempt (including
  // retries) gets a full TIMEOUT_CYC window. A real done on the expiry
  // cycle wins over the watchdog.
  assign wd_expire = (state == S_WAIT) && !mst_done && (wd_cnt == '0);
  assign done_eff  = mst_done || wd_expire;
  assign nack_eff  = mst_done ? mst_nack : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt       <= WDW'(TIMEOUT_CYC - 1);
      timeout_seen <= 1'b0;
    end else begin
      if (state != S_WAIT) begin
        wd_cnt <= WDW'(TIMEOUT_CYC - 1);
      end else if (wd_cnt != '0) begin
        wd_cnt <= wd_cnt - WDW'(1);
      end
      if (wd_expire) begin
        timeout_seen <= 1'b1;
      end
    end
  end

  assign err_flags = {timeout_seen, err_q};
`else
  assign done_eff  = mst_done;
  assign nack_eff  = mst_nack;
  assign err_flags = err_q;
`endif

  assign busy         = (state != S_IDLE);
  assign sample_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      slot  <= '0;
      retry <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      retry <= retry_nxt;
    end
  end

  // Dropping enable abandons the frame at the next safe point: an ISSUE not
  // yet accepted, or right after an in-flight transaction completes.
  always_comb begin
    state_nxt     = state;
    slot_nxt      = slot;
    retry_nxt     = retry;
    xact_ok       = 1'b0;
    xact_fail     = 1'b0;
    mst_cmd_valid = 1'b0;
    mst_cmd_addr  = '0;
    mst_cmd_reg   = '0;
    unique case (state)
      S_IDLE: begin
        if (tick) begin
          state_nxt = S_ISSUE;
          slot_nxt  = '0;
          retry_nxt = '0;
        end
      end
      S_ISSUE: begin
        mst_cmd_valid = 1'b1;
        mst_cmd_addr  = slot_addr(slot);
        mst_cmd_reg   = REG_DATA;
        if (mst_cmd_ready) begin
          state_nxt = S_WAIT;
        end else if (!enable) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (done_eff) begin
          if (!nack_eff) begin
            xact_ok   = 1'b1;
            state_nxt = enable ? S_NEXT : S_IDLE;
          end else if (retry < 3'(MAX_RETRY)) begin
            retry_nxt = retry + 3'd1;
            state_nxt = enable ? S_ISSUE : S_IDLE;
          end else begin
            xact_fail = 1'b1;
            state_nxt = enable ? S_NEXT : S_IDLE;
          end
        end
      end
      S_NEXT: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (slot == SLOT_LAST) begin
          state_nxt = S_DONE;
        end else begin
          slot_nxt  = slot + 2'd1;
          retry_nxt = '0;
          state_nxt = S_ISSUE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_o  <= '0;
      eco2_o  <= '0;
      press_o <= '0;
      light_o <= '0;
      err_q   <= '0;
      overrun <= 1'b0;
    end else begin
      if (xact_ok) begin
        unique case (slot)
          2'd0:    temp_o  <= mst_rdata;
          2'd1:    eco2_o  <= mst_rdata;
          2'd2:    press_o <= mst_rdata;
          default: light_o <= mst_rdata;
        endcase
        err_q[slot] <= 1'b0;
      end else if (xact_fail) begin
        err_q[slot] <= 1'b1;
      end
      if (tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_sensor_scheduler.sv
// Self-checking bench for i2c_sensor_scheduler: a sequential bus-functional
// I2C master answers each request, while a frame-level reference model
// (slot list, retry budget, last-good value per sensor) predicts requests,
// holding registers and error flags.
module tb_i2c_sensor_scheduler;

  localparam int POLL_DIV  = 200;
  localparam int MAX_RETRY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        mst_cmd_valid;
  logic        mst_cmd_ready;
  logic [6:0]  mst_cmd_addr;
  logic [7:0]  mst_cmd_reg;
  logic        mst_done;
  logic        mst_nack;
  logic [15:0] mst_rdata;
  logic [15:0] temp_o, eco2_o, press_o, light_o;
  logic        sample_valid;
`ifdef SCHED_TIMEOUT_EN
  logic [4:0]  err_flags;
`else
  logic [3:0]  err_flags;
`endif
  logic        overrun;
  logic        busy;

  i2c_sensor_scheduler #(
    .POLL_DIV  (POLL_DIV),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .mst_cmd_valid (mst_cmd_valid),
    .mst_cmd_ready (mst_cmd_ready),
    .mst_cmd_addr  (mst_cmd_addr),
    .mst_cmd_reg   (mst_cmd_reg),
    .mst_done      (mst_done),
    .mst_nack      (mst_nack),
    .mst_rdata     (mst_rdata),
    .temp_o        (temp_o),
    .eco2_o        (eco2_o),
    .press_o       (press_o),
    .light_o       (light_o),
    .sample_valid  (sample_valid),
    .err_flags     (err_flags),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  int cyc    = 0;
  int acc_cnt = 0;
  int sv_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mst_cmd_valid && mst_cmd_ready) acc_cnt <= acc_cnt + 1;
    if (sample_valid) sv_cnt <= sv_cnt + 1;
  end

  // Reference model state.
  logic [6:0]  tab [4];
  logic [15:0] exp_data [4];
  logic [3:0]  exp_err;

  // Frame configuration: mode 0 = always ACK, 1 = always NACK, 2 = random NACK.
  int          cfg_mode [4];
  logic [15:0] cfg_val [4];
  bit          cfg_rand;
  int          cfg_rdy_max;
  int          cfg_done_max;
  int          cfg_stall_slot;
  bit          cfg_long;

  bit          chk_period;
  int          prev_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    chk({pfx, "_valid"},   mst_cmd_valid, 0);
    chk({pfx, "_addr"},    mst_cmd_addr, 0);
    chk({pfx, "_reg"},     mst_cmd_reg, 0);
    chk({pfx, "_temp"},    temp_o, 0);
    chk({pfx, "_eco2"},    eco2_o, 0);
    chk({pfx, "_press"},   press_o, 0);
    chk({pfx, "_light"},   light_o, 0);
    chk({pfx, "_sv"},      sample_valid, 0);
    chk({pfx, "_err"},     32'(err_flags), 0);
    chk({pfx, "_overrun"}, overrun, 0);
    chk({pfx, "_busy"},    busy, 0);
  endtask

  task automatic check_data(input string pfx);
    chk({pfx, "_temp"},  temp_o,  exp_data[0]);
    chk({pfx, "_eco2"},  eco2_o,  exp_data[1]);
    chk({pfx, "_press"}, press_o, exp_data[2]);
    chk({pfx, "_light"}, light_o, exp_data[3]);
  endtask

  // One request/response exchange, driven and sampled on negedges.
  task automatic serve(input logic [6:0] exp_addr, input int rdy_lat, input int done_lat,
                       input logic nack, input logic [15:0] data, input bit drop_en,
                       output int start_cyc);
    int n;
    int acc0;
    n = 0;
    while (mst_cmd_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    start_cyc = cyc;
    chk("req_seen", mst_cmd_valid, 1);
    chk("req_addr", mst_cmd_addr, exp_addr);
    chk("req_reg", mst_cmd_reg, 8'h00);
    for (int i = 0; i < rdy_lat; i++) begin
      @(negedge clk);
      chk("stall_valid", mst_cmd_valid, 1);
      chk("stall_addr", mst_cmd_addr, exp_addr);
      chk("stall_reg", mst_cmd_reg, 8'h00);
    end
    acc0 = acc_cnt;
    mst_cmd_ready = 1'b1;
    @(negedge clk);
    mst_cmd_ready = 1'b0;
    if (drop_en) enable = 1'b0;
    chk("accept_once", acc_cnt - acc0, 1);
    chk("valid_drop", mst_cmd_valid, 0);
    for (int i = 0; i < done_lat; i++) begin
      @(negedge clk);
    end
    chk("wait_busy", busy, 1);
    mst_done  = 1'b1;
    mst_nack  = nack;
    mst_rdata = data;
    @(negedge clk);
    mst_done  = 1'b0;
    mst_nack  = 1'b0;
    mst_rdata = 16'($urandom);
  endtask

  task automatic run_frame();
    int acc0, sv0, nreq, st, rl, dl;
    logic nk, ok;
    logic [15:0] v;
    acc0 = acc_cnt;
    sv0  = sv_cnt;
    nreq = 0;
    for (int s = 0; s < 4; s++) begin
      ok = 1'b0;
      for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
        case (cfg_mode[s])
          1:       nk = 1'b1;
          2:       nk = ($urandom_range(0, 2) == 0);
          default: nk = 1'b0;
        endcase
        rl = (s == cfg_stall_slot && a == 0) ? 5 : int'($urandom_range(0, cfg_rdy_max));
        dl = (cfg_long && s == 0 && a == 0) ? 300 : int'($urandom_range(0, cfg_done_max));
        v  = cfg_rand ? 16'($urandom) : cfg_val[s];
        serve(tab[s], rl, dl, nk, v, 1'b0, st);
        if (s == 0 && a == 0) begin
          if (chk_period) chk("frame_period", st - prev_start, POLL_DIV);
          prev_start = st;
          chk_period = 1'b1;
        end
        nreq++;
        if (!nk) begin
          ok = 1'b1;
          exp_data[s] = v;
        end
      end
      exp_err[s] = !ok;
    end
    chk("sv_in_next", sample_valid, 0);
    @(negedge clk);
    chk("sv_pulse", sample_valid, 1);
    check_data("frame");
    chk("frame_err", 32'(err_flags[3:0]), exp_err);
    @(negedge clk);
    chk("sv_end", sample_valid, 0);
    chk("idle_after", busy, 0);
    chk("req_count", acc_cnt - acc0, nreq);
    chk("sv_count", sv_cnt - sv0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, st, sv0;
    logic [15:0] v0, v1, v2;

    tab[0] = 7'h44; tab[1] = 7'h5A; tab[2] = 7'h5C; tab[3] = 7'h23;
    for (int i = 0; i < 4; i++) exp_data[i] = '0;
    exp_err = '0;
    chk_period = 1'b0;
    prev_start = 0;
    cfg_stall_slot = -1;
    cfg_long = 1'b0;

    rst_n = 1'b0; enable = 1'b0; mst_cmd_ready = 1'b0;
    mst_done = 1'b0; mst_nack = 1'b0; mst_rdata = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Stray done / lone nack while idle must be ignored.
    mst_done = 1'b1; mst_rdata = 16'hBEEF;
    @(negedge clk);
    mst_done = 1'b0; mst_nack = 1'b1;
    @(negedge clk);
    mst_nack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_temp", temp_o, 0);
    chk("stray_err", 32'(err_flags), 0);
    chk("stray_busy", busy, 0);

    // First frame: fixed sensor values, first tick POLL_DIV cycles after enable.
    enable = 1'b1;
    n = 0;
    while (mst_cmd_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("first_tick_latency", n, POLL_DIV);
    cfg_mode = '{0, 0, 0, 0};
    cfg_val  = '{16'd250, 16'd600, 16'd1013, 16'd350};
    cfg_rand = 1'b0; cfg_rdy_max = 0; cfg_done_max = 2;
    run_frame();
    chk("f1_temp", temp_o, 16'd250);
    chk("f1_light", light_o, 16'd350);
    chk("f1_overrun", overrun, 0);

    // Randomized frames with random NACKs and handshake delays.
    for (int f = 0; f < 5; f++) begin
      for (int s = 0; s < 4; s++) cfg_mode[s] = int'($urandom_range(0, 1)) * 2;
      cfg_rand = 1'b1; cfg_rdy_max = 3; cfg_done_max = 5;
      run_frame();
    end

    // Ready held low 5 cycles on the eCO2 request.
    cfg_mode = '{0, 0, 0, 0};
    cfg_stall_slot = 1;
    run_frame();
    cfg_stall_slot = -1;
    chk("pre_drop_overrun", overrun, 0);

    // enable dropped while slot 2 is in flight.
    sv0 = sv_cnt;
    v0 = 16'($urandom); v1 = 16'($urandom); v2 = 16'($urandom);
    serve(tab[0], 0, 1, 1'b0, v0, 1'b0, st);
    serve(tab[1], 1, 2, 1'b0, v1, 1'b0, st);
    serve(tab[2], 0, 4, 1'b0, v2, 1'b1, st);
    exp_data[0] = v0; exp_data[1] = v1; exp_data[2] = v2;
    exp_err[2:0] = 3'b000;
    chk("drop_busy", busy, 0);
    repeat (6) @(negedge clk);
    check_data("drop");
    chk("drop_err", 32'(err_flags[2:0]), 0);
    chk("drop_no_sv", sv_cnt - sv0, 0);
    chk("drop_valid", mst_cmd_valid, 0);
    chk("drop_busy_late", busy, 0);
    chk_period = 1'b0;

    // Asynchronous reset while a transaction is in WAIT.
    enable = 1'b1;
    n = 0;
    while (mst_cmd_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_req_seen", mst_cmd_valid, 1);
    mst_cmd_ready = 1'b1;
    @(negedge clk);
    mst_cmd_ready = 1'b0;
    chk("rst_in_wait", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    for (int i = 0; i < 4; i++) exp_data[i] = '0;
    exp_err = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // eCO2 sensor never acknowledges: three attempts, then move on.
    cfg_mode = '{0, 1, 0, 0};
    cfg_rand = 1'b1; cfg_rdy_max = 2; cfg_done_max = 3;
    run_frame();
    chk("nack_err", 32'(err_flags[3:0]), 4'b0010);
    chk("nack_eco2", eco2_o, 16'd0);

    // Slow master: done 300 cycles late on the first request -> overrun.
    chk("pre_long_overrun", overrun, 0);
    cfg_mode = '{0, 0, 0, 0};
    cfg_long = 1'b1;
    run_frame();
    cfg_long = 1'b0;
    chk("long_overrun", overrun, 1);
    repeat (20) @(negedge clk);
    chk("long_no_restart", busy, 0);
    chk("long_overrun_sticky", overrun, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
